// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding and defaults for the IF/MEM single-port memory arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_D_BUSY  = 3'd1,
        ST_I_BUSY  = 3'd2,
        ST_I_DRAIN = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_t;

    localparam int TIMEOUT_DEF = 255;
    localparam int CNTW_DEF    = 8;

    // States in which a memory request is outstanding and the wait counter runs
    function automatic logic is_busy(input arb_state_t s);
        return (s == ST_D_BUSY) || (s == ST_I_BUSY) || (s == ST_I_DRAIN);
    endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating wait counter with clear/enable; o_tc flags the cycle that reaches TIMEOUT.
module arb_wait_cnt #(
    parameter int CNTW    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNTW-1:0] SAT_VAL = '1;
    localparam logic [CNTW-1:0] TC_VAL  = CNTW'(TIMEOUT - 1);

    logic [CNTW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != SAT_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Asserted on the wait cycle whose increment would make the count equal TIMEOUT
    assign o_tc = i_en && (r_cnt == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store, with
// flush cancellation of fetches, pipeline stall generation and a sticky timeout flag.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNTW    = CNTW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic [DWIDTH-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              d_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_o,
    output logic              err
);

    arb_state_t        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [AWIDTH-1:0] r_mem_addr;
    logic [DWIDTH-1:0] r_mem_wdata;
    logic [DWIDTH-1:0] r_if_rdata;
    logic [DWIDTH-1:0] r_d_rdata;
    logic              r_if_ready;
    logic              r_d_ready;
    logic              r_err;

    logic w_busy;
    logic w_grant_d;
    logic w_grant_i;
    logic w_tc;

    // After a timeout no new grants are issued, so the requester stays stalled until reset
    assign w_busy    = is_busy(r_state);
    assign w_grant_d = (r_state == ST_IDLE) && !r_err && d_req && !r_d_ready;
    assign w_grant_i = (r_state == ST_IDLE) && !r_err && !w_grant_d &&
                       if_req && !flush && !r_if_ready;

    arb_wait_cnt #(
        .CNTW    (CNTW),
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_grant_d || w_grant_i),
        .i_en  (w_busy && !mem_ack),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ST_D_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                    end else if (w_grant_i) begin
                        r_state    <= ST_I_BUSY;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= if_addr;
                    end
                end
                ST_D_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                        r_d_ready <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (w_tc) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_I_BUSY: begin
                    // An ack coinciding with a flush completes the bus cycle but drops the data
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (flush) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_if_rdata <= mem_rdata;
                            r_if_ready <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end else if (w_tc) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (flush) begin
                        r_state <= ST_I_DRAIN;
                    end
                end
                ST_I_DRAIN: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_tc) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;
    assign err       = r_err;

    // Drops on the ready-pulse cycle so the pipeline advances exactly then
    assign stall_o = !rst && ((d_req && !r_d_ready) || (if_req && !r_if_ready && !flush));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized transaction bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          flush;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_o;
    logic          err;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_if_rdata;
    logic [DW-1:0] m_d_rdata;
    logic          m_err;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DWIDTH  (DW),
        .AWIDTH  (AW),
        .TIMEOUT (TO),
        .CNTW    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_o   (stall_o),
        .err       (err)
    );

    task automatic check(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_if_rdata = '0;
        m_d_rdata  = '0;
        m_err      = 1'b0;
    endtask

    // Checks one cycle (inputs already applied) and advances to 1 time unit past the next edge
    task automatic look(input string tag, input bit e_req, input bit e_ir, input bit e_dr);
        logic e_stall;
        #1;
        e_stall = (d_req && !e_dr) || (if_req && !e_ir && !flush);
        check(tag, "mem_req", mem_req, e_req);
        if (e_req) begin
            check(tag, "mem_addr", mem_addr, m_addr);
            check(tag, "mem_we", mem_we, m_we);
            if (m_we) check(tag, "mem_wdata", mem_wdata, m_wdata);
        end
        check(tag, "if_ready", if_ready, e_ir);
        check(tag, "d_ready", d_ready, e_dr);
        check(tag, "stall_o", stall_o, e_stall);
        check(tag, "if_rdata", if_rdata, m_if_rdata);
        check(tag, "d_rdata", d_rdata, m_d_rdata);
        check(tag, "err", err, m_err);
        @(posedge clk);
        #1;
    endtask

    // One transaction from the idle request cycle to the ready pulse (or drop after a flush)
    task automatic serve(input string tag, input bit is_d, input logic [DW-1:0] rd,
                         input int delay, input int flush_at, input bit ack_in_done);
        bit fl;
        fl      = 1'b0;
        m_addr  = is_d ? d_addr : if_addr;
        m_we    = is_d ? d_we : 1'b0;
        m_wdata = d_wdata;
        look({tag, "/req"}, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= delay; k++) begin
            if (!is_d && k == flush_at) flush = 1'b1;
            look({tag, "/wait"}, 1'b1, 1'b0, 1'b0);
            if (flush) begin
                flush  = 1'b0;
                if_req = 1'b0;
                fl     = 1'b1;
            end
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        if (!is_d && flush_at == delay + 1) flush = 1'b1;
        look({tag, "/ack"}, 1'b1, 1'b0, 1'b0);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (flush) begin
            flush  = 1'b0;
            if_req = 1'b0;
            fl     = 1'b1;
        end
        if (fl) begin
            look({tag, "/drop"}, 1'b0, 1'b0, 1'b0);
        end else begin
            if (is_d) begin
                if (!m_we) m_d_rdata = rd;
            end else begin
                m_if_rdata = rd;
            end
            mem_ack = ack_in_done;
            look({tag, "/done"}, 1'b0, !is_d, is_d);
            mem_ack = 1'b0;
            if (is_d) d_req = 1'b0;
            else if_req = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        flush     = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        model_reset();
        m_addr  = '0;
        m_we    = 1'b0;
        m_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", "mem_req", mem_req, 1'b0);
        check("reset", "mem_addr", mem_addr, '0);
        check("reset", "if_ready", if_ready, 1'b0);
        check("reset", "d_ready", d_ready, 1'b0);
        check("reset", "stall_o", stall_o, 1'b0);
        check("reset", "err", err, 1'b0);
        rst = 1'b0;

        // Fetch alone, ack two cycles after mem_req
        if_req = 1'b1; if_addr = 32'h40;
        serve("t1", 1'b0, 32'h8C220004, 1, -1, 1'b0);

        // Simultaneous load and fetch: load first, fetch afterwards
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
        if_req = 1'b1; if_addr = 32'h44;
        serve("t2d", 1'b1, 32'h11112222, 1, -1, 1'b0);
        serve("t2i", 1'b0, 32'h33334444, 2, -1, 1'b0);

        // Store leaves d_rdata untouched
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        serve("t3", 1'b1, 32'h55555555, 2, -1, 1'b0);

        // Flush in I_BUSY, ack three cycles later, then a clean fetch
        if_req = 1'b1; if_addr = 32'h60;
        serve("t4f", 1'b0, 32'h66666666, 3, 1, 1'b0);
        if_req = 1'b1; if_addr = 32'h80;
        serve("t4", 1'b0, 32'h77777777, 1, -1, 1'b0);

        // Stray ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
        look("idleack", 1'b0, 1'b0, 1'b0);
        mem_ack = 1'b0;
        look("idleack2", 1'b0, 1'b0, 1'b0);

        // Flush in IDLE suppresses the fetch grant for that cycle only
        if_req = 1'b1; if_addr = 32'h90; flush = 1'b1;
        look("iflush", 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        serve("iflush", 1'b0, 32'h99990000, 0, -1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int kind;
            int dly;
            int fa;
            kind = $urandom_range(0, 2);
            if (kind != 1) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            if (kind != 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (kind != 1) begin
                dly = $urandom_range(0, TO - 1);
                serve("rnd_d", 1'b1, $urandom, dly, -1, 1'($urandom_range(0, 1)));
            end
            if (kind != 0) begin
                dly = $urandom_range(0, TO - 1);
                fa  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dly + 1) : -1;
                serve("rnd_i", 1'b0, $urandom, dly, fa, 1'($urandom_range(0, 1)));
            end
        end

        // Asynchronous reset in the middle of a data access
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        m_addr = d_addr; m_we = 1'b0;
        look("t6/req", 1'b0, 1'b0, 1'b0);
        look("t6/wait", 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t6_async", "mem_req", mem_req, 1'b0);
        check("t6_async", "stall_o", stall_o, 1'b0);
        check("t6_async", "d_ready", d_ready, 1'b0);
        check("t6_async", "err", err, 1'b0);
        check("t6_async", "d_rdata", d_rdata, '0);
        @(posedge clk);
        #1;
        rst = 1'b0; d_req = 1'b0;
        model_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h404;
        serve("t6/after", 1'b1, 32'hCAFEF00D, 2, -1, 1'b0);

        // No ack: timeout after TO wait cycles, err sticky, requester left stalled
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        m_addr = d_addr; m_we = 1'b0;
        look("t5/req", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < TO; k++) look("t5/wait", 1'b1, 1'b0, 1'b0);
        m_err = 1'b1;
        repeat (4) look("t5/stuck", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_rst", "err", err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0; d_req = 1'b0;
        model_reset();
        if_req = 1'b1; if_addr = 32'hA0;
        serve("t5/after", 1'b0, 32'h12345678, 1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
